// File: rtl/score_digit_display_pkg.sv
// Shared types and constants for the score readout: FSM states, character-cell
// geometry, font character codes and a power-of-ten helper for saturation.
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  localparam int         CELL_W     = 8;
  localparam int         CELL_H     = 16;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_digit_display_if.sv
// Conversion request channel between the game logic and the score readout.
interface score_digit_display_if #(
    parameter int SCORE_W = 14
);
    // update_req is a one-cycle request that samples score when accepted; busy
    // is high from the cycle after acceptance through COMMIT, done pulses when
    // the display register takes the new value.
    logic [SCORE_W-1:0] score;
    logic               update_req;
    logic               busy;
    logic               done;

    modport master (output score, update_req, input busy, done);
    modport slave  (input score, update_req, output busy, done);
endinterface

// File: rtl/score_digit_display_engine.sv
// Double-dabble binary-to-BCD shifter: one add-3/shift step per cycle, with
// a direct all-nines load for saturated scores.
module bcd_dd_engine #(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      step,
    input  logic                      load9,
    input  logic [SCORE_W-1:0]        din,
    output logic [4*NUM_DIGITS-1:0]   bcd
);
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic [SCORE_W-1:0] bin;
    logic [BCD_W-1:0]   adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin <= '0;
            bcd <= '0;
        end else if (start) begin
            bin <= din;
            bcd <= '0;
        end else if (load9) begin
            bcd <= {NUM_DIGITS{4'h9}};
        end else if (step) begin
            {bcd, bin} <= {adj, bin} << 1;
        end
    end

endmodule

// File: rtl/score_digit_display.sv
// Score readout: converts a binary score to BCD in the background and maps the
// current VGA pixel onto digit cells, producing font-ROM addresses one cycle later.
module score_digit_display
  import score_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 14,
    parameter int X0         = 535,
    parameter int Y0         = 289,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    score_digit_display_if.slave    upd,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic                    is_digit,
    output logic [2:0]              digit_sel,
    output logic [2:0]              pix_col,
    output logic [10:0]             addr_digit,
    output state_t                  fsm_state
);
    localparam int          BCD_W = 4 * NUM_DIGITS;
    localparam int          CNT_W = $clog2(SCORE_W + 1);
    localparam logic [63:0] MAX   = pow10(NUM_DIGITS) - 64'd1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               pending, pending_n;
    logic               start, step, load9, commit, sat;
    logic [BCD_W-1:0]   bcd, disp;

    assign sat       = 64'(upd.score) > MAX;
    assign upd.busy  = (state != ST_IDLE);
    assign upd.done  = (state == ST_COMMIT);
    assign fsm_state = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            cnt     <= '0;
            disp    <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            if (start)     cnt  <= '0;
            else if (step) cnt  <= cnt + 1'b1;
            if (commit)    disp <= bcd;
        end
    end

    // A pending request is served straight out of COMMIT, reusing the capture path.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        start     = 1'b0;
        step      = 1'b0;
        load9     = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (upd.update_req) begin
                    start   = !sat;
                    load9   = sat;
                    state_n = sat ? ST_COMMIT : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (upd.update_req) pending_n = 1'b1;
                if (cnt == CNT_W'(SCORE_W - 1)) state_n = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit = 1'b1;
                if (pending || upd.update_req) begin
                    pending_n = 1'b0;
                    start     = !sat;
                    load9     = sat;
                    state_n   = sat ? ST_COMMIT : ST_SHIFT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    bcd_dd_engine #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_engine (
        .clk   (Clk),
        .rst_n (Reset_n),
        .start (start),
        .step  (step),
        .load9 (load9),
        .din   (upd.score),
        .bcd   (bcd)
    );

    int         dx, dy;
    logic       hit, lz;
    logic [3:0] d, row_n;
    logic [7:0] ch, char_n;
    logic [2:0] sel_n, col_n;
    logic [10:0] addr_n;

    // lz tracks "every digit so far is zero", walking from the most significant cell.
    always_comb begin
        dx     = int'(DrawX) - X0;
        dy     = int'(DrawY) - Y0;
        hit    = (dx >= 0) && (dx < CELL_W * NUM_DIGITS) && (dy >= 0) && (dy < CELL_H);
        lz     = 1'b1;
        d      = '0;
        ch     = '0;
        char_n = '0;
        sel_n  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d  = disp[4*(NUM_DIGITS-1-k) +: 4];
            lz = lz && (d == 4'd0);
            ch = (BLANK_LZ != 0 && lz && k < NUM_DIGITS - 1) ? CHAR_SPACE
                                                             : CHAR_ZERO + {4'h0, d};
            if (hit && (dx / CELL_W) == k) begin
                char_n = ch;
                sel_n  = 3'(k);
            end
        end
        col_n  = hit ? 3'(dx % CELL_W) : 3'd0;
        row_n  = 4'(dy);
        addr_n = hit ? 11'({char_n, row_n}) : 11'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_digit   <= 1'b0;
            digit_sel  <= '0;
            pix_col    <= '0;
            addr_digit <= '0;
        end else begin
            is_digit   <= hit;
            digit_sel  <= sel_n;
            pix_col    <= col_n;
            addr_digit <= addr_n;
        end
    end

endmodule

// File: tb/tb_score_digit_display.sv
// Directed bench for score_digit_display: conversion timing, saturation, pending
// requests, reset abort and the pixel-to-cell mapping with blanking.
module tb_score_digit_display;
    import score_disp_pkg::*;

    localparam int ND = 4;
    localparam int SW = 14;
    localparam int PX0 = 535;
    localparam int PY0 = 289;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        is_digit;
    logic [2:0]  digit_sel, pix_col;
    logic [10:0] addr_digit;
    state_t      fsm_state;

    score_digit_display_if #(.SCORE_W(SW)) upd ();

    score_digit_display #(
        .NUM_DIGITS (ND),
        .SCORE_W    (SW),
        .X0         (PX0),
        .Y0         (PY0),
        .BLANK_LZ   (1)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .upd        (upd.slave),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .is_digit   (is_digit),
        .digit_sel  (digit_sel),
        .pix_col    (pix_col),
        .addr_digit (addr_digit),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model: {is_digit, digit_sel, pix_col, addr_digit} for a shown value
    function automatic logic [17:0] model(input int x, input int y, input int val);
        int dx, dy, k, p, dig, c;
        dx = x - PX0;
        dy = y - PY0;
        if (dx < 0 || dx >= 8 * ND || dy < 0 || dy >= 16) return 18'd0;
        k   = dx / 8;
        p   = int'(pow10(ND - 1 - k));
        dig = (val / p) % 10;
        c   = (k < ND - 1 && val < p) ? 32 : 48 + dig;
        return {1'b1, 3'(k), 3'(dx % 8), 11'(c * 16 + dy)};
    endfunction

    // drivers
    task automatic pix(input int x, input int y, output logic [17:0] got);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        got = {is_digit, digit_sel, pix_col, addr_digit};
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (upd.done) begin
                lat = k;
                return;
            end
            @(negedge Clk);
        end
    endtask

    task automatic convert(input int s, output int lat);
        upd.score      = SW'(s);
        upd.update_req = 1'b1;
        @(negedge Clk);
        upd.update_req = 1'b0;
        wait_done(lat);
        @(negedge Clk);
        check("busy_fall", int'(upd.busy), 0);
    endtask

    typedef struct {
        int score;
        int x;
        int y;
        int e_is;
        int e_sel;
        int e_col;
        int e_addr;
    } vec_t;

    vec_t vt[16];

    initial begin
        int lat, shown, dcnt, dseen;
        logic [17:0] got, e;

        vt[0]  = '{0,     559, 289, 1, 3, 0, 768};
        vt[1]  = '{0,     543, 289, 1, 1, 0, 512};
        vt[2]  = '{0,     562, 300, 1, 3, 3, 779};
        vt[3]  = '{1234,  543, 290, 1, 1, 0, 801};
        vt[4]  = '{1234,  535, 289, 1, 0, 0, 784};
        vt[5]  = '{1234,  566, 304, 1, 3, 7, 847};
        vt[6]  = '{1234,  567, 289, 0, 0, 0, 0};
        vt[7]  = '{1234,  534, 289, 0, 0, 0, 0};
        vt[8]  = '{1234,  540, 305, 0, 0, 0, 0};
        vt[9]  = '{57,    535, 289, 1, 0, 0, 512};
        vt[10] = '{57,    543, 289, 1, 1, 0, 512};
        vt[11] = '{57,    551, 290, 1, 2, 0, 849};
        vt[12] = '{57,    558, 291, 1, 2, 7, 850};
        vt[13] = '{57,    559, 289, 1, 3, 0, 880};
        vt[14] = '{12000, 547, 292, 1, 1, 4, 915};
        vt[15] = '{12000, 535, 288, 0, 0, 0, 0};

        upd.score      = '0;
        upd.update_req = 1'b0;
        DrawX          = 10'd559;
        DrawY          = 10'd289;
        repeat (3) @(negedge Clk);
        check("rst_busy",     int'(upd.busy), 0);
        check("rst_done",     int'(upd.done), 0);
        check("rst_state",    int'(fsm_state), int'(ST_IDLE));
        check("rst_is_digit", int'(is_digit), 0);
        check("rst_sel",      int'(digit_sel), 0);
        check("rst_col",      int'(pix_col), 0);
        check("rst_addr",     int'(addr_digit), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // score 0: busy next cycle, done after SCORE_W shift cycles
        upd.score      = '0;
        upd.update_req = 1'b1;
        @(negedge Clk);
        upd.update_req = 1'b0;
        check("busy_rise", int'(upd.busy), 1);
        wait_done(lat);
        check("done_lat_0", lat, SW + 1);
        @(negedge Clk);
        check("busy_fall_0", int'(upd.busy), 0);
        shown = 0;

        for (int i = 0; i < 16; i++) begin
            if (vt[i].score != shown) begin
                convert(vt[i].score, lat);
                check("done_lat", lat, (vt[i].score > 9999) ? 1 : SW + 1);
                shown = vt[i].score;
            end
            pix(vt[i].x, vt[i].y, got);
            check("vec_is_digit", int'(got[17]),    vt[i].e_is);
            check("vec_sel",      int'(got[16:14]), vt[i].e_sel);
            check("vec_col",      int'(got[13:11]), vt[i].e_col);
            check("vec_addr",     int'(got[10:0]),  vt[i].e_addr);
        end

        // back-to-back: second request lands mid-conversion, score then held at 908
        upd.score      = SW'(57);
        upd.update_req = 1'b1;
        @(negedge Clk);
        upd.score = SW'(908);
        @(negedge Clk);
        upd.update_req = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (upd.done) dcnt++;
            @(negedge Clk);
        end
        check("b2b_done_count", dcnt, 2);
        check("b2b_idle", int'(upd.busy), 0);
        shown = 908;
        pix(535, 289, got);
        check("b2b_cell0_addr", int'(got[10:0]), 512);
        pix(559, 289, got);
        check("b2b_cell3_addr", int'(got[10:0]), 896);
        for (int k = 1; k < 3; k++) begin
            pix(PX0 + 8 * k + 2, 293, got);
            check("b2b_cell", int'(got), int'(model(PX0 + 8 * k + 2, 293, shown)));
        end

        // reset during a conversion of 4321
        upd.score      = SW'(4321);
        upd.update_req = 1'b1;
        @(negedge Clk);
        upd.update_req = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        check("abort_busy", int'(upd.busy), 0);
        check("abort_done", int'(upd.done), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        dseen = 0;
        repeat (25) begin
            @(negedge Clk);
            if (upd.done) dseen = 1;
        end
        check("abort_no_done", dseen, 0);
        check("abort_busy_after", int'(upd.busy), 0);
        shown = 0;
        for (int k = 0; k < ND; k++) begin
            pix(PX0 + 8 * k + 1, 290, got);
            check("abort_cell", int'(got), int'(model(PX0 + 8 * k + 1, 290, shown)));
        end

        // sweep: each output sample must match the pixel driven one cycle earlier
        exp_q.delete();
        for (int yi = 0; yi < 2; yi++) begin
            for (int x = 534; x <= 568; x++) begin
                @(negedge Clk);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sweep", int'({is_digit, digit_sel, pix_col, addr_digit}), int'(e));
                end
                DrawX = 10'(x);
                DrawY = 10'((yi == 0) ? 289 : 305);
                exp_q.push_back(model(x, (yi == 0) ? 289 : 305, shown));
            end
        end
        @(negedge Clk);
        e = exp_q.pop_front();
        check("sweep", int'({is_digit, digit_sel, pix_col, addr_digit}), int'(e));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
